rx_cmd_parser: RTL and testbench
================================

// Module: rx_cmd_parser
// PURPOSE
//   UART receive-side command decoder: consumes ASCII bytes from the UART RX byte
//   stream and decodes LF-terminated lines into control pulses and a rate value.
//   Counterpart of the TX status-string generator: the host sends "init", "norm",
//   "start" or "rate:<n>" and this block drives the mode/rate controls of the design.
// PARAMETERS
//   MAX_LINE      36   max bytes per line, excluding LF; longer lines are rejected
//   DEFAULT_RATE  8'd1 value of oRATE after reset
// PORTS
//   clk           in   1  system clock, all logic on rising edge
//   reset         in   1  synchronous reset, active-high
//   iRX_VALID     in   1  one-cycle strobe: iRX_DATA holds a received byte
//   iRX_DATA      in   8  received byte, sampled only when iRX_VALID=1
//   oRATE         out  8  last accepted rate value (binary), held between updates
//   oRATE_VALID   out  1  one-cycle pulse: oRATE updated by a "rate:" line
//   oCMD_INITIAL  out  1  one-cycle pulse: line "init" accepted
//   oCMD_NORMAL   out  1  one-cycle pulse: line "norm" accepted
//   oCMD_START    out  1  one-cycle pulse: line "start" accepted
//   oERR          out  1  one-cycle pulse: malformed/overlong line rejected
//   oBUSY         out  1  high while a line is partially received (state != IDLE)
// BEHAVIOUR
//   Reset: all pulse outputs 0, oBUSY 0, oRATE=DEFAULT_RATE, state IDLE, counters 0.
//   Reset mid-line discards the partial line; no pulse is emitted for it.
//   Byte classes: LF 0x0A terminates line; CR 0x0D and space 0x20 ignored (not
//   counted toward MAX_LINE); digits 0x30-0x39; everything else is a literal char.
//   Matching is case-sensitive, lowercase only. iRX_VALID may be high every cycle.
//   States:
//   - IDLE: LF -> stay, no output (empty line). Literal -> KEYWORD, char index 1,
//     candidate set = keywords whose first char matches; none -> DISCARD.
//   - KEYWORD: compare byte to char[idx] of remaining candidates ("init","norm",
//     "start","rate"); drop mismatches; none left -> DISCARD. After "rate" fully
//     matched, ':' -> DIGITS (acc=0, ndig=0); anything else -> DISCARD.
//     LF with exactly one fully matched command keyword -> fire its pulse, IDLE;
//     LF otherwise (partial keyword, "rate" without ':') -> oERR, IDLE.
//   - DIGITS: digit -> acc = acc*10 + (byte-0x30) in 10-bit arithmetic, ndig+1;
//     non-digit literal, ndig would exceed 3, or acc > 255 -> DISCARD.
//     LF with ndig>=1 -> oRATE<=acc[7:0], oRATE_VALID pulse, IDLE; ndig=0 -> oERR.
//     Leading zeros allowed within the 3-digit limit ("007" = 7).
//   - DISCARD: ignore all bytes until LF; at LF -> oERR pulse, IDLE.
//   Length: byte counter (6 bit) increments per counted byte; reaching MAX_LINE+1
//     counted bytes in any state -> DISCARD. Counter clears on LF and reset.
//   Latency: every pulse and the oRATE update are registered, asserted in the cycle
//     after the clock edge that samples the terminating LF; width exactly 1 cycle.
//   At most one of oCMD_*/oRATE_VALID/oERR is high in any cycle.
//   oRATE changes only together with oRATE_VALID; rejected lines never modify it.
// TESTING
//   "init\n" back-to-back bytes -> oCMD_INITIAL=1 for 1 cycle after LF, others 0.
//   "rate:123\r\n" -> oRATE=8'd123, oRATE_VALID 1-cycle pulse; "rate:7\n" -> 8'd7.
//   "rate:256\n", "rate:\n", "rate:1a\n", "rate:0012\n" -> oERR each, oRATE unchanged.
//   "sta" then reset asserted mid-line, then "start\n" -> only one oCMD_START, no oERR.
//   40 literal bytes then LF -> oBUSY high during line, single oERR at LF; "\n" alone -> no pulse.
//   "norm\n" with iRX_VALID gaps of 0..5 idle cycles between bytes -> oCMD_NORMAL once.

Source files
------------

// File: rtl/rx_cmd_parser_if.sv
// Byte-stream and control bundle between the UART RX path and the command parser.
// iRX_VALID is a one-cycle strobe with no back-pressure: the parser accepts a
// byte in every cycle iRX_VALID is high, so the producer never waits.
interface rx_cmd_parser_if;
    logic       iRX_VALID;
    logic [7:0] iRX_DATA;
    logic [7:0] oRATE;
    logic       oRATE_VALID;
    logic       oCMD_INITIAL;
    logic       oCMD_NORMAL;
    logic       oCMD_START;
    logic       oERR;
    logic       oBUSY;
    logic [1:0] dbg_state;

    modport master (
        output iRX_VALID, iRX_DATA,
        input  oRATE, oRATE_VALID, oCMD_INITIAL, oCMD_NORMAL, oCMD_START,
               oERR, oBUSY, dbg_state
    );

    modport slave (
        input  iRX_VALID, iRX_DATA,
        output oRATE, oRATE_VALID, oCMD_INITIAL, oCMD_NORMAL, oCMD_START,
               oERR, oBUSY, dbg_state
    );
endinterface

// File: rtl/rx_cmd_parser.sv
// Decodes LF-terminated ASCII lines ("init", "norm", "start", "rate:<n>") into
// one-cycle control pulses and a held 8-bit rate value. Malformed or overlong
// lines produce a single oERR pulse at their LF.
module rx_cmd_parser #(
    parameter int         MAX_LINE     = 36,
    parameter logic [7:0] DEFAULT_RATE = 8'd1
) (
    input logic        clk,
    input logic        reset,
    rx_cmd_parser_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_KEYWORD = 2'd1,
        ST_DIGITS  = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    // Candidate bit order: 0 init, 1 norm, 2 start, 3 rate
    function automatic logic [7:0] kw_char(input logic [1:0] k, input logic [2:0] i);
        logic [7:0] c;
        c = 8'h00;
        case ({k, i})
            5'b00_000: c = "i";
            5'b00_001: c = "n";
            5'b00_010: c = "i";
            5'b00_011: c = "t";
            5'b01_000: c = "n";
            5'b01_001: c = "o";
            5'b01_010: c = "r";
            5'b01_011: c = "m";
            5'b10_000: c = "s";
            5'b10_001: c = "t";
            5'b10_010: c = "a";
            5'b10_011: c = "r";
            5'b10_100: c = "t";
            5'b11_000: c = "r";
            5'b11_001: c = "a";
            5'b11_010: c = "t";
            5'b11_011: c = "e";
            default:   c = 8'h00;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] kw_len(input logic [1:0] k);
        return (k == 2'd2) ? 3'd5 : 3'd4;
    endfunction

    state_t      state_q;
    logic [3:0]  cand_q;
    logic [2:0]  idx_q;
    logic [5:0]  cnt_q;
    logic [9:0]  acc_q;
    logic [1:0]  ndig_q;
    logic [7:0]  rate_q;
    logic        rate_valid_q;
    logic        cmd_init_q;
    logic        cmd_norm_q;
    logic        cmd_start_q;
    logic        err_q;

    logic        is_lf;
    logic        is_skip;
    logic        is_digit;
    logic        counted;
    logic        overlong;
    logic [3:0]  first_mask;
    logic [3:0]  step_mask;
    logic        full_init;
    logic        full_norm;
    logic        full_start;
    logic        rate_full;
    logic [9:0]  acc_d;
    logic [5:0]  cnt_d;

    // Classify the incoming byte and precompute keyword/digit progress
    always_comb begin
        is_lf    = (bus.iRX_DATA == 8'h0A);
        is_skip  = (bus.iRX_DATA == 8'h0D) || (bus.iRX_DATA == 8'h20);
        is_digit = (bus.iRX_DATA >= 8'h30) && (bus.iRX_DATA <= 8'h39);
        counted  = bus.iRX_VALID && !is_lf && !is_skip;
        // This byte would be counted byte number MAX_LINE+1
        overlong = counted && (cnt_q >= 6'(MAX_LINE));
        cnt_d    = overlong ? cnt_q : cnt_q + 6'd1;

        first_mask = 4'b0000;
        step_mask  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            first_mask[k] = (kw_char(2'(k), 3'd0) == bus.iRX_DATA);
            step_mask[k]  = cand_q[k] && (idx_q < kw_len(2'(k)))
                            && (kw_char(2'(k), idx_q) == bus.iRX_DATA);
        end

        full_init  = cand_q[0] && (idx_q == 3'd4);
        full_norm  = cand_q[1] && (idx_q == 3'd4);
        full_start = cand_q[2] && (idx_q == 3'd5);
        rate_full  = cand_q[3] && (idx_q == 3'd4);

        // ndig_q < 3 guarantees acc_q <= 99, so this cannot overflow 10 bits
        acc_d = (acc_q * 10'd10) + {6'd0, bus.iRX_DATA[3:0]};
    end

    // Line FSM: consumes one byte per strobe, all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cand_q       <= 4'b0000;
            idx_q        <= 3'd0;
            cnt_q        <= 6'd0;
            acc_q        <= 10'd0;
            ndig_q       <= 2'd0;
            rate_q       <= DEFAULT_RATE;
            rate_valid_q <= 1'b0;
            cmd_init_q   <= 1'b0;
            cmd_norm_q   <= 1'b0;
            cmd_start_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rate_valid_q <= 1'b0;
            cmd_init_q   <= 1'b0;
            cmd_norm_q   <= 1'b0;
            cmd_start_q  <= 1'b0;
            err_q        <= 1'b0;

            if (bus.iRX_VALID && is_lf) begin
                cnt_q   <= 6'd0;
                state_q <= ST_IDLE;
                case (state_q)
                    ST_IDLE: ;
                    ST_KEYWORD: begin
                        if (full_init)       cmd_init_q  <= 1'b1;
                        else if (full_norm)  cmd_norm_q  <= 1'b1;
                        else if (full_start) cmd_start_q <= 1'b1;
                        else                 err_q       <= 1'b1;
                    end
                    ST_DIGITS: begin
                        if (ndig_q != 2'd0) begin
                            rate_q       <= acc_q[7:0];
                            rate_valid_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    ST_DISCARD: err_q <= 1'b1;
                    default: ;
                endcase
            end else if (counted) begin
                cnt_q <= cnt_d;
                if (overlong) begin
                    state_q <= ST_DISCARD;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (|first_mask) begin
                                state_q <= ST_KEYWORD;
                                cand_q  <= first_mask;
                                idx_q   <= 3'd1;
                            end else begin
                                state_q <= ST_DISCARD;
                            end
                        end
                        ST_KEYWORD: begin
                            if (rate_full && bus.iRX_DATA == 8'h3A) begin
                                state_q <= ST_DIGITS;
                                acc_q   <= 10'd0;
                                ndig_q  <= 2'd0;
                            end else if (|step_mask) begin
                                cand_q <= step_mask;
                                idx_q  <= idx_q + 3'd1;
                            end else begin
                                state_q <= ST_DISCARD;
                            end
                        end
                        ST_DIGITS: begin
                            if (is_digit && ndig_q != 2'd3 && acc_d <= 10'd255) begin
                                acc_q  <= acc_d;
                                ndig_q <= ndig_q + 2'd1;
                            end else begin
                                state_q <= ST_DISCARD;
                            end
                        end
                        ST_DISCARD: ;
                        default: state_q <= ST_DISCARD;
                    endcase
                end
            end
        end
    end

    assign bus.oRATE        = rate_q;
    assign bus.oRATE_VALID  = rate_valid_q;
    assign bus.oCMD_INITIAL = cmd_init_q;
    assign bus.oCMD_NORMAL  = cmd_norm_q;
    assign bus.oCMD_START   = cmd_start_q;
    assign bus.oERR         = err_q;
    assign bus.oBUSY        = (state_q != ST_IDLE);
    assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Bench for rx_cmd_parser: table of lines with expected events plus hand-written
// sequences for reset mid-line, overlong lines and irregular byte gaps.
module tb_rx_cmd_parser;

    localparam int K_NONE  = 0;
    localparam int K_INIT  = 1;
    localparam int K_NORM  = 2;
    localparam int K_START = 3;
    localparam int K_RATE  = 4;
    localparam int K_ERR   = 5;

    typedef struct {
        string line;
        int    kind;
        int    rate;
    } vec_t;

    logic clk;
    logic reset;
    rx_cmd_parser_if bus ();

    rx_cmd_parser #(.MAX_LINE(36), .DEFAULT_RATE(8'd1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  model_rate;
    vec_t        vecs[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: act=%0h req=%0h", name, act, req);
    endtask

    // scoreboard: pop one expected event per observed pulse
    always @(negedge clk) begin
        logic [4:0]  pulses;
        logic [7:0]  kind;
        logic [15:0] exp;
        pulses = {bus.oCMD_INITIAL, bus.oCMD_NORMAL, bus.oCMD_START, bus.oRATE_VALID, bus.oERR};
        if (!reset && pulses != 5'd0) begin
            chk("onehot", 32'($countones(pulses)), 32'd1);
            kind = bus.oCMD_INITIAL ? 8'(K_INIT) : bus.oCMD_NORMAL ? 8'(K_NORM) :
                   bus.oCMD_START ? 8'(K_START) : bus.oRATE_VALID ? 8'(K_RATE) : 8'(K_ERR);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {16'd0, kind, bus.oRATE}, 32'd0);
            end else begin
                exp = exp_q.pop_front();
                chk("event", {16'd0, kind, bus.oRATE}, {16'd0, exp});
            end
        end
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input int gap);
        if (gap > 0) begin
            bus.iRX_VALID = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
        bus.iRX_VALID = 1'b1;
        bus.iRX_DATA  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        bus.iRX_VALID = 1'b0;
        bus.iRX_DATA  = 8'h00;
    endtask

    task automatic expect_event(input int kind, input int rate);
        if (kind == K_RATE) model_rate = 8'(rate);
        if (kind != K_NONE) exp_q.push_back({8'(kind), model_rate});
    endtask

    // bytes before the last are sent, then the expectation is pushed before the LF
    task automatic send_line(input string s, input int kind, input int rate, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            if (i == s.len() - 1) expect_event(kind, rate);
            send_byte(s[i], $urandom_range(0, max_gap));
        end
        go_idle();
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (exp_q.size() > 0) begin
            chk(name, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic void add(input string l, input int k, input int r);
        vec_t v;
        v.line = l;
        v.kind = k;
        v.rate = r;
        vecs.push_back(v);
    endfunction

    initial begin
        add("init\n",       K_INIT,  0);
        add("rate:123\r\n", K_RATE,  123);
        add("rate:7\n",     K_RATE,  7);
        add("rate:256\n",   K_ERR,   0);
        add("rate:\n",      K_ERR,   0);
        add("rate:1a\n",    K_ERR,   0);
        add("rate:0012\n",  K_ERR,   0);
        add("norm\n",       K_NORM,  0);
        add("start\n",      K_START, 0);
        add("\n",           K_NONE,  0);
        add("rate:042\n",   K_RATE,  42);
        add("inix\n",       K_ERR,   0);
        add("ini\n",        K_ERR,   0);
        add("rate\n",       K_ERR,   0);
        add("Init\n",       K_ERR,   0);
        add("in it\r\n",    K_INIT,  0);
        add("start1\n",     K_ERR,   0);
        add("rate:255\n",   K_RATE,  255);
        add("rate: 9 \r\n", K_RATE,  9);
        add("xyz\n",        K_ERR,   0);
        add("initinit\n",   K_ERR,   0);
        add("rate:0\n",     K_RATE,  0);
        add("rate;5\n",     K_ERR,   0);

        model_rate = 8'd1;
        reset = 1'b1;
        go_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rate", 32'(bus.oRATE), 32'd1);
        chk("reset_busy", 32'(bus.oBUSY), 32'd0);
        chk("reset_pulses", {27'd0, bus.oCMD_INITIAL, bus.oCMD_NORMAL, bus.oCMD_START,
                             bus.oRATE_VALID, bus.oERR}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // table-driven lines, back-to-back bytes and then with short gaps
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < vecs.size(); v++) begin
                send_line(vecs[v].line, vecs[v].kind, vecs[v].rate, pass * 2);
                drain("drain_table");
                chk("idle_after_line", 32'(bus.oBUSY), 32'd0);
            end
        end

        // reset mid-line discards the partial line silently
        send_line("sta", K_NONE, 0, 0);
        chk("busy_partial", 32'(bus.oBUSY), 32'd1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_after_reset", 32'(bus.oBUSY), 32'd0);
        chk("rate_after_reset", 32'(bus.oRATE), 32'd1);
        reset = 1'b0;
        model_rate = 8'd1;
        send_line("start\n", K_START, 0, 0);
        drain("drain_reset");

        // 40 literal bytes: busy throughout, single error at LF
        for (int i = 0; i < 40; i++) begin
            send_byte(8'($urandom_range(97, 122)), 0);
            if (i == 0 || i == 20 || i == 39) chk("busy_long", 32'(bus.oBUSY), 32'd1);
        end
        expect_event(K_ERR, 0);
        send_byte(8'h0A, 0);
        go_idle();
        drain("drain_long");
        chk("busy_long_end", 32'(bus.oBUSY), 32'd0);

        // rate line padded past the length limit must not update the rate
        send_line("rate:5xxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxxx\n", K_ERR, 0, 0);
        drain("drain_long_rate");

        // irregular gaps between bytes
        for (int r = 0; r < 4; r++) begin
            send_line("norm\n", K_NORM, 0, 5);
            drain("drain_gap");
        end
        send_line("rate:200\n", K_RATE, 200, 5);
        drain("drain_gap_rate");
        chk("rate_hold", 32'(bus.oRATE), 32'd200);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
